// File: rtl/inst_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
// Holds the default word width and the memory-side FSM encoding.
package inst_prefetch_buffer_pkg;

    localparam int IFB_XLEN = 32;

    typedef enum logic [1:0] {
        IFB_IDLE  = 2'd0,
        IFB_FETCH = 2'd1,
        IFB_DRAIN = 2'd2
    } ifb_state_e;

endpackage

// File: rtl/inst_prefetch_buffer_fifo.sv
// Prefetch FIFO of {addr, inst} entries.
// Power-of-2 depth, wrapping pointers, single-cycle flush.
module inst_prefetch_buffer_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Sequential instruction prefetch queue between CPU and program memory.
// PREFETCH_STATS_EN adds saturating hit/miss counter outputs.
module inst_prefetch_buffer
    import inst_prefetch_buffer_pkg::*;
#(
    parameter int              XLEN     = IFB_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_cpu_req,
    input  logic [XLEN-1:0] i_cpu_addr,
    output logic            o_cpu_ack,
    output logic [XLEN-1:0] o_cpu_inst,
    output logic            o_mem_req,
    output logic [XLEN-1:0] o_mem_addr,
    input  logic            i_mem_ack,
    input  logic [XLEN-1:0] i_mem_data
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0]     o_hit_count,
    output logic [31:0]     o_miss_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    ifb_state_e        state;
    logic [XLEN-1:0]   fetch_addr;
    logic [2*XLEN-1:0] head;
    logic [XLEN-1:0]   head_addr;
    logic [XLEN-1:0]   head_inst;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic              count_unused;
    logic              cpu_valid;
    logic              hit;
    logic              pending;
    logic              flush;
    logic              push;

    assign {head_addr, head_inst} = head;
    assign count_unused = ^count;

    assign cpu_valid = i_cpu_req && !o_cpu_ack;
    assign hit       = cpu_valid && !empty && (head_addr == i_cpu_addr);
    // Empty queue already heading for this PC: wait instead of flushing.
    assign pending   = empty &&
                       ((fetch_addr == i_cpu_addr) ||
                        (state == IFB_FETCH && o_mem_addr == i_cpu_addr));
    assign flush     = cpu_valid && !hit && !pending;
    assign push      = (state == IFB_FETCH) && i_mem_ack && !flush;

    inst_prefetch_buffer_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .pop   (hit),
        .flush (flush),
        .wdata ({o_mem_addr, i_mem_data}),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IFB_IDLE;
            fetch_addr <= RESET_PC;
            o_mem_req  <= 1'b0;
            o_mem_addr <= '0;
            o_cpu_ack  <= 1'b0;
            o_cpu_inst <= '0;
        end else begin
            o_cpu_ack <= hit;
            if (hit)
                o_cpu_inst <= head_inst;
            unique case (state)
                IFB_IDLE: begin
                    if (!full && !flush) begin
                        o_mem_req  <= 1'b1;
                        o_mem_addr <= fetch_addr;
                        state      <= IFB_FETCH;
                    end
                end
                IFB_FETCH: begin
                    if (i_mem_ack) begin
                        o_mem_req  <= 1'b0;
                        fetch_addr <= o_mem_addr + XLEN'(4);
                        state      <= IFB_IDLE;
                    end else if (flush) begin
                        state <= IFB_DRAIN;
                    end
                end
                IFB_DRAIN: begin
                    if (i_mem_ack) begin
                        o_mem_req <= 1'b0;
                        state     <= IFB_IDLE;
                    end
                end
                default: state <= IFB_IDLE;
            endcase
            // Redirect wins over the sequential increment.
            if (flush)
                fetch_addr <= {i_cpu_addr[XLEN-1:2], 2'b00};
        end
    end

`ifdef PREFETCH_STATS_EN
    logic req_flushed;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_flushed  <= 1'b0;
            o_hit_count  <= '0;
            o_miss_count <= '0;
        end else begin
            if (flush) begin
                req_flushed <= 1'b1;
                if (o_miss_count != '1)
                    o_miss_count <= o_miss_count + 1'b1;
            end
            if (hit) begin
                req_flushed <= 1'b0;
                if (!req_flushed && o_hit_count != '1)
                    o_hit_count <= o_hit_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Directed self-checking bench for inst_prefetch_buffer.
// Memory model returns ~addr after a programmable ack latency.
module tb_inst_prefetch_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_ack;
    logic [31:0] cpu_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
`ifdef PREFETCH_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int          total = 0;
    int          bad   = 0;
    int          mem_lat = 0;
    int          cnt = 0;
    logic        force_ack = 1'b0;
    logic [31:0] log_q [$];
    logic [31:0] inst;
    int          lat;

    always #5 clk = ~clk;

    inst_prefetch_buffer u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cpu_req    (cpu_req),
        .i_cpu_addr   (cpu_addr),
        .o_cpu_ack    (cpu_ack),
        .o_cpu_inst   (cpu_inst),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .i_mem_ack    (mem_ack),
        .i_mem_data   (mem_data)
`ifdef PREFETCH_STATS_EN
        ,
        .o_hit_count  (hit_count),
        .o_miss_count (miss_count)
`endif
    );

    assign mem_ack  = force_ack | (mem_req && cnt >= mem_lat);
    assign mem_data = force_ack ? 32'hDEAD_BEEF : ~mem_addr;

    always @(posedge clk) begin
        cnt <= (mem_req && !mem_ack) ? cnt + 1 : 0;
        if (mem_req && mem_ack)
            log_q.push_back(mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] logq(input int i);
        return (log_q.size() > i) ? log_q[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cpu_fetch(input logic [31:0] addr,
                             output logic [31:0] got, output int l);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        got      = 32'hxxxx_xxxx;
        l        = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            l++;
            if (cpu_ack) begin
                got = cpu_inst;
                break;
            end
        end
        cpu_req = 1'b0;
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] addr,
                            input bit chk_lat);
        logic [31:0] g;
        int          l;
        cpu_fetch(addr, g, l);
        check(tag, g, ~addr);
        if (chk_lat)
            check({tag, "_lat"}, 32'(l), 32'd1);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            found = mem_req && (mem_addr == addr);
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        cpu_req  = 1'b0;
        cpu_addr = '0;
        tick();
        check("rst_cpu_ack",  {31'd0, cpu_ack}, 32'd0);
        check("rst_cpu_inst", cpu_inst, 32'd0);
        check("rst_mem_req",  {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);

        // fill to full with an idle CPU
        rst = 1'b0;
        log_q.delete();
        repeat (20) tick();
        check("fill_count", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("fill_addr", logq(i), 32'(4 * i));
        check("fill_req_idle", {31'd0, mem_req}, 32'd0);
        log_q.delete();
        do_fetch("fill_hit0", 32'h0, 1'b1);
        repeat (6) tick();
        check("refill_count", 32'(log_q.size()), 32'd1);
        check("refill_addr", logq(0), 32'h10);
        check("refill_idle", {31'd0, mem_req}, 32'd0);

        // jump away from a full queue
        log_q.delete();
        tick();
        do_fetch("jump_inst", 32'h40, 1'b0);
        check("jump_addr", logq(0), 32'h40);
        tick();
        do_fetch("jump_next", 32'h44, 1'b0);

        // primed sequential stream
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (12) tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            do_fetch("stream", 32'(4 * i), 1'b1);
        end

        // hit coinciding with a push keeps count
        repeat (10) tick();
        log_q.delete();
        do_fetch("pp_a", 32'h20, 1'b1);
        tick();
        do_fetch("pp_b", 32'h24, 1'b1);
        repeat (8) tick();
        check("pp_count", 32'(log_q.size()), 32'd2);
        check("pp_addr0", logq(0), 32'h30);
        check("pp_addr1", logq(1), 32'h34);
        check("pp_idle", {31'd0, mem_req}, 32'd0);

        // flush while the fetch of 0x8 is outstanding
        mem_lat = 3;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_req("drain_seen8", 32'h8);
        log_q.delete();
        cpu_req  = 1'b1;
        cpu_addr = 32'h100;
        tick();
        check("drain_hold_req", {31'd0, mem_req}, 32'd1);
        check("drain_hold_addr", mem_addr, 32'h8);
        cpu_fetch(32'h100, inst, lat);
        check("drain_inst", inst, ~32'h100);
        check("drain_log0", logq(0), 32'h8);
        check("drain_log1", logq(1), 32'h100);
        tick();
        do_fetch("drain_next", 32'h104, 1'b0);

        // reset in the middle of a fetch, then a stray ack
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_req("post_rst_pc", 32'h0);
        rst = 1'b1;
        tick();
        check("mid_rst_ack",  {31'd0, cpu_ack}, 32'd0);
        check("mid_rst_inst", cpu_inst, 32'd0);
        check("mid_rst_req",  {31'd0, mem_req}, 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        rst       = 1'b0;
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        check("late_ack_req",  {31'd0, mem_req}, 32'd1);
        check("late_ack_addr", mem_addr, 32'h0);
        do_fetch("late_ack_inst", 32'h0, 1'b0);

`ifdef PREFETCH_STATS_EN
        mem_lat = 0;
        rst = 1'b1;
        tick();
        check("stats_rst_hit",  hit_count, 32'd0);
        check("stats_rst_miss", miss_count, 32'd0);
        rst = 1'b0;
        repeat (12) tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            do_fetch("stats_stream", 32'(4 * i), 1'b0);
        end
        tick();
        do_fetch("stats_jump", 32'h40, 1'b0);
        check("stats_hit",  hit_count, 32'd3);
        check("stats_miss", miss_count, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_prefetch_buffer.md
Name: inst_prefetch_buffer

Overview:
- Sequential instruction prefetch queue between the CPU instruction port and program memory.
- Issues word fetches ahead of the CPU on its own, starting from the last requested PC and stepping +4.
- Returns hits from a DEPTH-entry FIFO. Flushes and refetches when the CPU asks for a non-sequential PC (jump or branch).
- Both sides use the codebase's req/ack instruction handshake.

Parameters:
- XLEN, `XLEN (32): address and instruction width.
- DEPTH, 4: FIFO entries; must be a power of 2 and at least 2.
- RESET_PC, 32'h0000_0000: first prefetch address after reset.

Ports:
- i_clk  in  1  system clock; single clock domain, all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_cpu_req  in  1  CPU instruction request; held until o_cpu_ack.
- i_cpu_addr  in  XLEN  requested PC.
- o_cpu_ack  out  1  registered one-cycle ack.
- o_cpu_inst  out  XLEN  instruction; valid while o_cpu_ack=1.
- o_mem_req  out  1  program-memory request.
- o_mem_addr  out  XLEN  word-aligned fetch address.
- i_mem_ack  in  1  memory ack; data valid in the same cycle.
- i_mem_data  in  XLEN  fetched instruction.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - FIFO emptied: rd_ptr=wr_ptr=0, count=0.
  - fetch_addr=RESET_PC; state=IDLE.
  - o_cpu_ack=0, o_cpu_inst=0, o_mem_req=0, o_mem_addr=0.
  - Reset mid-transaction drops all state. Any ack returning for a pre-reset request is ignored, because state is IDLE.
- FIFO entry = {addr, inst}. count is log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
  - Full: count==DEPTH. Empty: count==0.
- Memory FSM:
  - IDLE:
    - if !full and no flush this cycle: o_mem_req<=1, o_mem_addr<=fetch_addr, go to FETCH.
  - FETCH:
    - o_mem_req and o_mem_addr held stable until i_mem_ack.
    - On ack: push {o_mem_addr, i_mem_data}; fetch_addr+=4, wrapping modulo 2^XLEN; o_mem_req<=0; go to IDLE.
    - At most one request outstanding.
    - If a flush occurs in the same cycle as ack: data is discarded, no push.
    - If a flush occurs with no ack: go to DRAIN.
  - DRAIN:
    - o_mem_req held until i_mem_ack; the returned data is discarded; then go to IDLE.
    - Memory never sees a request withdrawn before its ack.
- CPU side, evaluated when i_cpu_req=1 and o_cpu_ack=0 (requests are ignored in the ack cycle):
  - Hit: !empty and head.addr==i_cpu_addr.
    - Next cycle: o_cpu_ack=1, o_cpu_inst=head.inst; pop.
  - Miss: empty with the in-flight or next address equal to i_cpu_addr → wait, no flush.
  - Miss otherwise (flush):
    - count<=0 and pointers reset.
    - fetch_addr<={i_cpu_addr[XLEN-1:2],2'b00}.
    - FSM goes to DRAIN if a request is in flight, else IDLE.
- Push and pop in the same cycle: count unchanged.
- Push while full cannot occur; the FSM never requests when full.
- Latency:
  - Hit: 1 cycle from the sampled request.
  - Cold miss: drain (if a request is in flight) + memory latency + 2.
- o_cpu_ack is never high for two consecutive cycles.

Optional Feature:
- Macro: PREFETCH_STATS_EN.
- Defined: adds outputs o_hit_count and o_miss_count (32 bits each), saturating at 32'hFFFF_FFFF, cleared by i_rst.
  - Hit is counted when a hit ack is issued with no flush since the CPU request.
  - Miss is counted per flush.
- Undefined: no ports and no counter logic.

Decomposition:
- header.vh: `XLEN; the FSM state encodings IFB_IDLE=2'd0, IFB_FETCH=2'd1, IFB_DRAIN=2'd2.
- Sub-module ifb_fifo (DEPTH, WIDTH=2*XLEN):
  - interface: push, pop, flush, head, full, empty, count.
  - holds the pointer and count logic.
- The top level holds the FSM, the hit/flush compare and the CPU ack register.

Test Plan:
- Sequential stream:
  - Stimulus: reset, RESET_PC=0, zero-wait memory; CPU requests 0,4,8,…,28.
  - Response: all ack; o_cpu_inst matches memory; steady state has 1-cycle hit latency once the FIFO is primed.
- Fill-to-full:
  - Stimulus: CPU idle after reset for 20 cycles.
  - Response: exactly DEPTH=4 memory requests (addresses 0,4,8,12); o_mem_req stays 0 afterwards.
  - Then request 0: ack next cycle, one new fetch of 16.
- Jump flush:
  - Stimulus: FIFO holds 0–12; CPU requests 0x40.
  - Response: flush; next memory address 0x40; ack with mem[0x40]; stale entries are never returned.
- Flush during outstanding fetch:
  - Stimulus: memory with 3-cycle ack latency; jump to 0x100 while the fetch of 0x8 is pending.
  - Response: the req of 0x8 is held until its ack, then its data is dropped; next request is 0x100; CPU gets mem[0x100].
- Simultaneous push/pop and reset:
  - Stimulus: push and pop in the same cycle, count unchanged. Then assert i_rst mid-FETCH.
  - Response: all outputs 0 next cycle; a late ack is ignored; first post-reset request is RESET_PC.
- Stats, with PREFETCH_STATS_EN defined:
  - Stimulus: stream 0,4,8 then jump to 0x40.
  - Response: o_hit_count=3 and o_miss_count=1 after the 0x40 ack.
    - 0 counts as a hit because no flush occurred.
